alu_op_issuer: RTL and testbench

//  Initiator side of the ALU operand/write-enable interface. Accepts one operation
//  per valid/ready request, drives ALUOp/A/B into the ALU, holds them stable until
//  the ALU's We asserts, captures Result/C, and returns them through a 1-deep

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_op_issuer_if.sv | 52 +++++
 rtl/alu_timeout_cnt.sv | 41 ++++
 rtl/alu_op_issuer.sv | 142 ++++++++++++++
 tb/tb_alu_op_issuer.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU operation issuer: ALU opcode encodings,
// the issuer FSM state type and a small opcode helper.
// -----------------------------------------------------------------------------
package alu_pkg;

  // ALU opcodes as seen on the ALUOp bus
  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_SLT  = 3'd4;
  localparam logic [2:0] OP_ADD  = 3'd5;
  localparam logic [2:0] OP_ADD2 = 3'd6;  // subtract (Sub_En)
  localparam logic [2:0] OP_MOD  = 3'd7;  // multi-cycle modulo

  // Issuer FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // The modulo unit is the only multi-cycle operation; its We line is stale
  // in the first cycle an operation is presented.
  function automatic logic is_mod_op(input logic [2:0] op);
    return (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_op_issuer_if.sv
// -----------------------------------------------------------------------------
// alu_op_issuer_if
// Bundles the three handshakes around the issuer:
//   request  : req_valid/req_ready, req_op, req_a, req_b, req_tag
//   ALU side : ALUOp, A, B (to ALU); alu_we, alu_result, alu_c (from ALU)
//   response : rsp_valid/rsp_ready, rsp_result, rsp_c, rsp_tag, rsp_err
// Modports:
//   master : the issuer itself
//   slave  : its environment (decode stage, ALU and response consumer)
// -----------------------------------------------------------------------------
interface alu_op_issuer_if #(
  parameter int TAG_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [31:0]       req_a;
  logic [31:0]       req_b;
  logic [TAG_W-1:0]  req_tag;

  logic [2:0]        ALUOp;
  logic [31:0]       A;
  logic [31:0]       B;
  logic              alu_we;
  logic [31:0]       alu_result;
  logic              alu_c;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_result;
  logic              rsp_c;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_err;

  modport master (
    input  req_valid, req_op, req_a, req_b, req_tag,
    output req_ready,
    output ALUOp, A, B,
    input  alu_we, alu_result, alu_c,
    output rsp_valid, rsp_result, rsp_c, rsp_tag, rsp_err,
    input  rsp_ready
  );

  modport slave (
    output req_valid, req_op, req_a, req_b, req_tag,
    input  req_ready,
    input  ALUOp, A, B,
    output alu_we, alu_result, alu_c,
    input  rsp_valid, rsp_result, rsp_c, rsp_tag, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_timeout_cnt.sv
// -----------------------------------------------------------------------------
// alu_timeout_cnt
// Saturating cycle counter used to bound the wait for the ALU's We.
// Ports:
//   i_clk     : clock, rising edge
//   i_rst_n   : asynchronous active-low reset
//   i_clear   : synchronous clear (wins over enable)
//   i_enable  : count one cycle
//   o_expired : counter has reached TIMEOUT_CYC-1
// -----------------------------------------------------------------------------
module alu_timeout_cnt #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int              CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  // Cycle counter: stops at the last value so it never wraps back to zero
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !o_expired) begin
      r_cnt <= r_cnt + CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_expired = (r_cnt == CNT_LAST);

endmodule

// File: rtl/alu_op_issuer.sv
// -----------------------------------------------------------------------------
// alu_op_issuer
// Initiator side of the ALU operand/write-enable interface. Takes one request
// at a time, drives ALUOp/A/B from registers until the ALU raises We, captures
// Result/C into a 1-deep response register and holds it until consumed.
// Modulo operations wait for We with a timeout; expiry returns rsp_err=1.
// Ports:
//   Clk   : clock, rising edge
//   Reset : asynchronous active-low reset
//   bus   : alu_op_issuer_if.master (request, ALU and response signals)
// -----------------------------------------------------------------------------
module alu_op_issuer
  import alu_pkg::*;
#(
  parameter int TAG_W       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic            Clk,
  input  logic            Reset,
  alu_op_issuer_if.master bus
);

  state_e            r_state;
  logic [2:0]        r_aluop;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic [TAG_W-1:0]  r_tag;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_result;
  logic              r_rsp_c;
  logic [TAG_W-1:0]  r_rsp_tag;
  logic              r_rsp_err;

  logic              w_accept;
  logic              w_capture;
  logic              w_abort;
  logic              w_cnt_en;
  logic              w_expired;

  alu_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout_cnt (
    .i_clk     (Clk),
    .i_rst_n   (Reset),
    .i_clear   (w_accept),
    .i_enable  (w_cnt_en),
    .o_expired (w_expired)
  );

  // Decode accept / capture / abort events from the current state
  always_comb begin
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_abort   = 1'b0;
    w_cnt_en  = 1'b0;
    w_accept  = (r_state == ST_IDLE) && bus.req_valid;
    w_cnt_en  = (r_state == ST_WAIT);
    if (r_state == ST_ISSUE) begin
      // We seen while a modulo is first presented belongs to the previous op
      w_capture = bus.alu_we && !is_mod_op(r_aluop);
    end else if (r_state == ST_WAIT) begin
      w_capture = bus.alu_we;
    end else begin
      w_capture = 1'b0;
    end
    // A We arriving on the expiry cycle takes priority over the abort
    w_abort = (r_state == ST_WAIT) && !bus.alu_we && w_expired;
  end

  // Issuer FSM with registered ALU-side and response outputs
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state      <= ST_IDLE;
      r_aluop      <= OP_AND;
      r_a          <= 32'd0;
      r_b          <= 32'd0;
      r_tag        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= 32'd0;
      r_rsp_c      <= 1'b0;
      r_rsp_tag    <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_aluop <= bus.req_op;
            r_a     <= bus.req_a;
            r_b     <= bus.req_b;
            r_tag   <= bus.req_tag;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w_capture) begin
            r_state <= ST_RESP;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_capture || w_abort) begin
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase

      // Load the response and release the ALU inputs; zero operands drop
      // Mod_En so an unfinished modulo is abandoned.
      if (w_capture || w_abort) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_result <= w_capture ? bus.alu_result : 32'd0;
        r_rsp_c      <= w_capture & bus.alu_c;
        r_rsp_err    <= w_abort;
        r_rsp_tag    <= r_tag;
        r_aluop      <= OP_AND;
        r_a          <= 32'd0;
        r_b          <= 32'd0;
      end
    end
  end

  assign bus.req_ready  = (r_state == ST_IDLE);
  assign bus.ALUOp      = r_aluop;
  assign bus.A          = r_a;
  assign bus.B          = r_b;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_c      = r_rsp_c;
  assign bus.rsp_tag    = r_rsp_tag;
  assign bus.rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_alu_op_issuer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_issuer
// Scoreboard bench: requests push their expected response, a monitor pops and
// compares on every response handshake. A behavioural ALU model answers the
// issuer; modulo latency is chosen per request. The timeout window is 8, so
// the longest modulo that still completes has 7 idle We cycles.
// -----------------------------------------------------------------------------
module tb_alu_op_issuer;
  import alu_pkg::*;

  localparam int TAG_W = 4;
  localparam int TO    = 8;

  typedef struct {
    logic [31:0]      res;
    logic             c;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_op_issuer_if #(.TAG_W(TAG_W)) bus();

  alu_op_issuer #(
    .TAG_W       (TAG_W),
    .TIMEOUT_CYC (TO)
  ) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t sbq[$];
  int   lat_cur = 0;
  logic rdy_low  = 1'b0;
  logic rdy_rand = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference ALU: {carry, result}
  function automatic logic [32:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] r;
    case (op)
      3'd0: r = {1'b0, a & b};
      3'd1: r = {1'b0, a | b};
      3'd2: r = {1'b0, a ^ b};
      3'd3: r = {1'b0, ~(a | b)};
      3'd4: r = {32'd0, ($signed(a) < $signed(b))};
      3'd5: r = {1'b0, a} + {1'b0, b};
      3'd6: r = {1'b0, a} + {1'b0, ~b} + 33'd1;
      3'd7: r = (b == 32'd0) ? 33'd0 : {1'b0, a % b};
      default: r = 33'd0;
    endcase
    return r;
  endfunction

  // ALU model: immediate We for single-cycle ops; modulo raises a stale We in
  // its first cycle, then We stays low for lat_cur wait cycles.
  initial begin
    int          mod_cnt;
    logic [31:0] hold_a, hold_b;
    logic [32:0] r;
    mod_cnt = 0;
    hold_a = 32'd0;
    hold_b = 32'd0;
    bus.alu_we = 1'b0;
    bus.alu_result = 32'd0;
    bus.alu_c = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.ALUOp == OP_MOD) begin
        mod_cnt++;
        if (mod_cnt == 1) begin
          hold_a = bus.A;
          hold_b = bus.B;
        end else begin
          chk("mod_a_stable", bus.A, hold_a);
          chk("mod_b_stable", bus.B, hold_b);
        end
      end else begin
        mod_cnt = 0;
      end
      r = alu_ref(bus.ALUOp, bus.A, bus.B);
      if (bus.ALUOp != OP_MOD) begin
        bus.alu_we = 1'b1;
        bus.alu_result = r[31:0];
        bus.alu_c = r[32];
      end else if (mod_cnt <= 1) begin
        bus.alu_we = 1'b1;
        bus.alu_result = 32'hBAD0_BAD0;
        bus.alu_c = 1'b1;
      end else if (mod_cnt > lat_cur + 1) begin
        bus.alu_we = 1'b1;
        bus.alu_result = r[31:0];
        bus.alu_c = r[32];
      end else begin
        bus.alu_we = 1'b0;
        bus.alu_result = 32'hDEAD_BEEF;
        bus.alu_c = 1'b1;
      end
    end
  end

  // Response consumer readiness, changed just after each rising edge
  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_low) bus.rsp_ready = 1'b0;
      else if (rdy_rand) bus.rsp_ready = 1'($urandom_range(0, 1));
      else bus.rsp_ready = 1'b1;
    end
  end

  // Monitor: response checks against the scoreboard and protocol checks
  initial begin
    logic        prev_valid, prev_hs;
    logic [37:0] prev_f, cur_f;
    exp_t        e;
    prev_valid = 1'b0;
    prev_hs = 1'b0;
    prev_f = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        prev_hs = 1'b0;
      end else begin
        cur_f = {bus.rsp_result, bus.rsp_c, bus.rsp_tag, bus.rsp_err};
        if (prev_hs) chk("ready_after_hs", bus.req_ready, 1'b1);
        if (bus.rsp_valid) begin
          chk("req_ready_in_resp", bus.req_ready, 1'b0);
          chk("aluop_in_resp", bus.ALUOp, OP_AND);
          chk("ab_in_resp", {bus.A, bus.B}, 64'd0);
          if (prev_valid && !prev_hs) chk("rsp_stable", cur_f, prev_f);
          if (bus.rsp_ready) begin
            if (sbq.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_rsp actual=valid required=none");
            end else begin
              e = sbq.pop_front();
              chk("rsp_result", bus.rsp_result, e.res);
              chk("rsp_c", bus.rsp_c, e.c);
              chk("rsp_tag", bus.rsp_tag, e.tag);
              chk("rsp_err", bus.rsp_err, e.err);
            end
          end
        end
        prev_valid = bus.rsp_valid;
        prev_hs = bus.rsp_valid && bus.rsp_ready;
        prev_f = cur_f;
      end
    end
  end

  // Present one request and push its expected response once accepted
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, input int lat);
    int          n;
    logic [32:0] r;
    exp_t        e;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      total++;
      bad++;
      $display("FAIL req_ready_wait actual=0 required=1");
      return;
    end
    lat_cur = lat;
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_a = a;
    bus.req_b = b;
    bus.req_tag = tag;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    r = alu_ref(op, a, b);
    if (op == OP_MOD && lat >= TO) e = '{res: 32'd0, c: 1'b0, tag: tag, err: 1'b1};
    else e = '{res: r[31:0], c: r[32], tag: tag, err: 1'b0};
    sbq.push_back(e);
  endtask

  // Count falling edges from acceptance until rsp_valid is seen
  task automatic wait_rsp(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.rsp_valid && cyc < 100);
  endtask

  task automatic chk_reset_vals(input string tagname);
    chk({tagname, "_req_ready"}, bus.req_ready, 1'b1);
    chk({tagname, "_aluop"}, bus.ALUOp, 3'd0);
    chk({tagname, "_a"}, bus.A, 32'd0);
    chk({tagname, "_b"}, bus.B, 32'd0);
    chk({tagname, "_rsp"}, {bus.rsp_valid, bus.rsp_result, bus.rsp_c, bus.rsp_tag, bus.rsp_err}, 64'd0);
  endtask

  initial begin
    int cyc;
    int n;
    bus.req_valid = 1'b0;
    bus.req_op = 3'd0;
    bus.req_a = 32'd0;
    bus.req_b = 32'd0;
    bus.req_tag = '0;
    #1;
    chk_reset_vals("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // ADD 5+7
    issue(OP_ADD, 32'd5, 32'd7, 4'd3, 0);
    chk("add_aluop_issue", bus.ALUOp, 3'b101);
    wait_rsp(cyc);
    chk("add_latency", cyc, 2);
    chk("add_result", bus.rsp_result, 32'd12);
    chk("add_tag", bus.rsp_tag, 4'd3);

    // SUB 0-1
    issue(OP_ADD2, 32'd0, 32'd1, 4'd5, 0);
    wait_rsp(cyc);
    chk("sub_result", bus.rsp_result, 32'hFFFF_FFFF);

    // Modulo 17%5 completing on the last cycle before expiry
    issue(OP_MOD, 32'd17, 32'd5, 4'd9, TO - 1);
    wait_rsp(cyc);
    chk("mod_latency", cyc, TO + 2);
    chk("mod_result", bus.rsp_result, 32'd2);
    chk("mod_err", bus.rsp_err, 1'b0);

    // Modulo that never completes
    issue(OP_MOD, 32'd9, 32'd4, 4'd10, 1000);
    wait_rsp(cyc);
    chk("timeout_latency", cyc, TO + 2);
    chk("timeout_err", bus.rsp_err, 1'b1);
    chk("timeout_result", bus.rsp_result, 32'd0);
    chk("timeout_aluop", bus.ALUOp, 3'b000);

    // Consumer stalls five cycles, then a back-to-back request
    rdy_low = 1'b1;
    issue(OP_XOR, 32'hF0F0_1234, 32'h0FF0_4321, 4'd12, 0);
    wait_rsp(cyc);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", bus.rsp_valid, 1'b1);
      chk("stall_req_ready", bus.req_ready, 1'b0);
    end
    rdy_low = 1'b0;
    issue(OP_SLT, 32'hFFFF_FFFE, 32'd1, 4'd13, 0);

    // Random traffic with a randomly stalling consumer
    rdy_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      logic [31:0] b;
      op = 3'($urandom_range(0, 7));
      b = (op == OP_MOD) ? 32'($urandom_range(0, 20)) : $urandom;
      issue(op, $urandom, b, 4'($urandom_range(0, 15)), int'($urandom_range(0, TO + 2)));
    end
    rdy_rand = 1'b0;
    n = 0;
    while (sbq.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sbq.size(), 0);

    // Reset asserted while a modulo is waiting
    issue(OP_MOD, 32'd100, 32'd7, 4'd6, 1000);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_reset_no_rsp", bus.rsp_valid, 1'b0);
    end

    // Normal operation after recovery
    issue(OP_OR, 32'h1200_0000, 32'h0000_0034, 4'd15, 0);
    wait_rsp(cyc);
    chk("recover_latency", cyc, 2);
    repeat (3) @(negedge clk);
    chk("final_drain", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
